triumph_imem: RTL and testbench
===============================

# triumph_imem

Instruction memory responder for the Triumph core: answers the fetch stage's word-address request with a 32-bit instruction in the same cycle, and owns a byte-serial program loader that fills the array before the core runs. Sits between the fetch stage's instruction address and data ports and an external program-load source, such as a UART byte receiver or testbench. While a load is in progress it asserts a hold to freeze the core.

## Interface
- DEPTH, 32: number of 32-bit instruction words.
- AW, 5: word-index width, equal to log2(DEPTH).

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- instr_addr_i  in  32  word index from the fetch stage; the PC increments by 1 per instruction.
- instr_rdata_o  out  32  instruction at instr_addr_i.
- ld_start_i  in  1  pulse; (re)starts a program load at word 0.
- ld_valid_i  in  1  a byte is offered on ld_data_i.
- ld_data_i  in  8  program byte, little-endian within each word.
- ld_last_i  in  1  qualifies the offered byte as the final byte of the program.
- ld_ready_o  out  1  the loader accepts the offered byte this cycle.
- ld_words_o  out  AW+1  count of words written by the current or most recent load.
- ld_csum_o  out  8  running byte checksum (see Configuration).
- core_hold_o  out  1  core must not fetch or advance.

## Operation
- States:
  - IDLE: reset state; no program present.
  - LOAD: accepting bytes.
  - RUN: serving fetches.
- Transitions:
  - IDLE→LOAD on ld_start_i.
  - LOAD→RUN on an accepted byte with ld_last_i=1, or when word DEPTH-1 is written.
  - RUN→LOAD on ld_start_i.
  - LOAD→LOAD on ld_start_i: restarts the load.
- ld_ready_o = (state==LOAD) & ~ld_start_i. This is combinational; ld_start_i always wins over a simultaneous byte, and that byte is not accepted.
- A byte is accepted when ld_valid_i & ld_ready_o.
- Byte assembly:
  - The first accepted byte goes to bits [7:0], the second to [15:8], and so on.
  - A 2-bit byte counter wraps 3→0.
  - On the 4th byte the full word is written to mem[wptr] at that edge, wptr increments, and ld_words_o increments.
- ld_last_i on a partial word (byte counter 0–2): the word is written immediately with the unfilled upper bytes set to 0, and ld_words_o increments.
- On ld_start_i:
  - wptr, byte counter, ld_words_o and the checksum clear to 0.
  - Any partial word is discarded.
  - Array contents are not cleared; words beyond the new load keep their old values.
- Read path:
  - In RUN, instr_rdata_o = mem[instr_addr_i[AW-1:0]] if instr_addr_i < DEPTH, else 32'h0.
  - In IDLE and LOAD, instr_rdata_o = 32'h0.
- core_hold_o = (state != RUN).
- Reset mid-load: the partial load is abandoned and state returns to IDLE. A new ld_start_i is required before the core runs.

## Timing
- Reset values:
  - state IDLE; wptr, byte counter and ld_words_o = 0; ld_csum_o = 0.
  - Outputs: ld_ready_o 0, core_hold_o 1, instr_rdata_o 32'h0.
  - The memory array is not reset.
- Read latency is 0 cycles (combinational), so the fetch stage samples the instruction in the same cycle it drives the address.
- Write latency: a word written at edge N is readable from cycle N+1.
- State changes: LOAD→RUN happens at the edge that accepts the last byte. core_hold_o drops and reads become valid in the next cycle.
- Throughput is one byte per cycle when ld_valid_i is held high.
- At 32 words, ld_words_o reads DEPTH (6'd32) and the loader leaves LOAD; no wrap and no overwrite of word 0.

## Configuration
- TRIUMPH_IMEM_CHECKSUM_EN defined:
  - ld_csum_o is the modulo-256 sum of all bytes accepted since the last ld_start_i.
  - It updates at each accepting edge, including the last byte.
- Undefined: ld_csum_o is tied to 8'h00 and no adder is built.

## Test plan
- Reset, then no load: core_hold_o=1, instr_rdata_o=0, ld_ready_o=0 for 10 cycles. ld_valid_i pulses are ignored and ld_words_o stays 0.
- ld_start_i, then bytes 13,00,50,00,93,00,10,00 streamed back-to-back, last on the 8th byte: mem[0]=32'h00500013, mem[1]=32'h00100093, ld_words_o=2. The state is RUN one cycle after the last byte, and addr 1 reads 32'h00100093 that same cycle.
- Partial word: load bytes AA,BB with last on BB → mem[0]=32'h0000BBAA, ld_words_o=1. With the checksum macro, ld_csum_o=8'h65.
- Full array: stream 128 bytes without ld_last_i → ld_words_o=32 and the state goes to RUN. ld_ready_o=0 afterwards, and addr 40 reads 32'h0.
- ld_start_i coincident with a valid byte after 2 bytes of a word: that byte is not accepted and the partial word is discarded. The following 4 bytes land in mem[0].
- rst_i asserted asynchronously mid-load, on the 3rd byte of word 5: core_hold_o=1 and instr_rdata_o=0 immediately. After release the state is IDLE and ld_words_o=0.

Source files
------------

// File: rtl/triumph_imem_if.sv
// Bus bundle between triumph_imem, the core's fetch stage and the program-load source.
interface triumph_imem_if #(
    parameter int AW = 5
);
    logic [31:0] instr_addr_i;
    logic [31:0] instr_rdata_o;
    logic        ld_start_i;
    logic        ld_valid_i;
    logic [7:0]  ld_data_i;
    logic        ld_last_i;
    logic        ld_ready_o;
    logic [AW:0] ld_words_o;
    logic [7:0]  ld_csum_o;
    logic        core_hold_o;

    modport slave (
        input  instr_addr_i, ld_start_i, ld_valid_i, ld_data_i, ld_last_i,
        output instr_rdata_o, ld_ready_o, ld_words_o, ld_csum_o, core_hold_o
    );

    modport master (
        output instr_addr_i, ld_start_i, ld_valid_i, ld_data_i, ld_last_i,
        input  instr_rdata_o, ld_ready_o, ld_words_o, ld_csum_o, core_hold_o
    );
endinterface

// File: rtl/triumph_imem.sv
// Triumph instruction memory: zero-latency fetch port plus byte-serial program loader.
// Optional TRIUMPH_IMEM_CHECKSUM_EN adds a modulo-256 sum of loaded bytes on ld_csum_o.
module triumph_imem #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    triumph_imem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

    localparam logic [AW:0] LAST_WORD = (AW+1)'(DEPTH - 1);

    state_e      state_q, state_d;
    logic [AW:0] words_q, words_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] buf_q, buf_d;
    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        wr_en;
    logic [31:0] merged;

    assign bus.ld_ready_o = (state_q == LOAD) & ~bus.ld_start_i;
    assign accept         = bus.ld_valid_i & bus.ld_ready_o;
    assign wr_en          = accept & ((bcnt_q == 2'd3) | bus.ld_last_i);
    // Unfilled bytes of buf_q are always zero, so a short final word is zero-padded for free.
    assign merged         = {8'h00, buf_q} | (32'(bus.ld_data_i) << {bcnt_q, 3'b000});

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        bcnt_d  = bcnt_q;
        buf_d   = buf_q;
        if (bus.ld_start_i) begin
            state_d = LOAD;
            words_d = '0;
            bcnt_d  = '0;
            buf_d   = '0;
        end else if (accept) begin
            bcnt_d = wr_en ? 2'd0 : bcnt_q + 2'd1;
            buf_d  = wr_en ? 24'h0 : merged[23:0];
            if (wr_en) begin
                words_d = words_q + 1'b1;
                if (bus.ld_last_i || words_q == LAST_WORD) begin
                    state_d = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            words_q <= '0;
            bcnt_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            bcnt_q  <= bcnt_d;
            buf_q   <= buf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[words_q[AW-1:0]] <= merged;
        end
    end

    assign bus.instr_rdata_o = (state_q == RUN && bus.instr_addr_i < 32'(DEPTH))
                               ? mem[bus.instr_addr_i[AW-1:0]] : 32'h0;
    assign bus.core_hold_o   = (state_q != RUN);
    assign bus.ld_words_o    = words_q;

`ifdef TRIUMPH_IMEM_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (bus.ld_start_i) begin
            csum_d = '0;
        end else if (accept) begin
            csum_d = csum_q + bus.ld_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign bus.ld_csum_o = csum_q;
`else
    assign bus.ld_csum_o = 8'h00;
`endif
endmodule

// File: tb/tb_triumph_imem.sv
// Self-checking bench for triumph_imem against a byte-list reference model of program loading.
module tb_triumph_imem;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef TRIUMPH_IMEM_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    triumph_imem_if #(.AW(AW)) bus ();

    triumph_imem #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_mem   [DEPTH];
    bit          exp_known [DEPTH];
    int          exp_words = 0;
    logic [7:0]  exp_csum  = 8'h00;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: words are little-endian groups of 4 bytes, a final short group is
    // zero-padded only when ld_last ends it, and the array stops at DEPTH words.
    task automatic model_load(input byte_q_t q, input bit last);
        int n;
        int nw;
        logic [31:0] w;
        n  = q.size();
        nw = last ? (n + 3) / 4 : n / 4;
        if (nw > DEPTH) nw = DEPTH;
        for (int k = 0; k < nw; k++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++)
                if (4*k + b < n) w[8*b +: 8] = q[4*k + b];
            exp_mem[k]   = w;
            exp_known[k] = 1'b1;
        end
        exp_words = nw;
        exp_csum  = 8'h00;
        for (int i = 0; i < n && i < 4*DEPTH; i++) exp_csum = exp_csum + q[i];
    endtask

    task automatic pulse_start();
        bus.ld_start_i = 1'b1;
        step();
        bus.ld_start_i = 1'b0;
    endtask

    task automatic drive_load(input byte_q_t q, input bit last, input bit gaps, output int miss);
        miss = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.ld_valid_i = 1'b0;
                    bus.ld_data_i  = 8'($urandom);
                    step();
                end
            end
            bus.ld_valid_i = 1'b1;
            bus.ld_data_i  = q[i];
            bus.ld_last_i  = last && (i == q.size() - 1);
            #1;
            if (bus.ld_ready_o !== 1'b1) miss++;
            @(posedge clk_i);
            #1;
            bus.ld_valid_i = 1'b0;
            bus.ld_last_i  = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        rst_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.ld_valid_i   = 1'($urandom_range(0, 1));
            bus.ld_data_i    = 8'($urandom);
            bus.instr_addr_i = 32'($urandom_range(0, 40));
            #1;
            checks++;
            if (bus.core_hold_o !== 1'b1 || bus.instr_rdata_o !== 32'h0 || bus.ld_ready_o !== 1'b0 ||
                bus.ld_words_o !== 6'd0 || bus.ld_csum_o !== 8'h00) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d hold=%b rdata=%h ready=%b words=%0d csum=%h required hold=1 rdata=0 ready=0 words=0 csum=0",
                         c, bus.core_hold_o, bus.instr_rdata_o, bus.ld_ready_o, bus.ld_words_o, bus.ld_csum_o);
            end
            step();
        end
        bus.ld_valid_i = 1'b0;
    endtask

    task automatic test_directed_program();
        byte_q_t q;
        int miss;
        q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        pulse_start();
        model_load(q, 1'b1);
        drive_load(q, 1'b1, 1'b0, miss);
        bus.instr_addr_i = 32'd1;
        #1;
        checks++;
        if (miss != 0 || bus.core_hold_o !== 1'b0 || bus.instr_rdata_o !== 32'h00100093) begin
            failures++;
            $display("FAIL directed_run_next_cycle miss=%0d hold=%b rdata1=%h required miss=0 hold=0 rdata1=00100093",
                     miss, bus.core_hold_o, bus.instr_rdata_o);
        end
        bus.instr_addr_i = 32'd0;
        #1;
        checks++;
        if (bus.instr_rdata_o !== 32'h00500013 || bus.ld_words_o !== 6'd2 ||
            bus.ld_csum_o !== (CSUM_EN ? 8'h06 : 8'h00)) begin
            failures++;
            $display("FAIL directed_word0 rdata0=%h words=%0d csum=%h required 00500013 words=2 csum=%h",
                     bus.instr_rdata_o, bus.ld_words_o, bus.ld_csum_o, CSUM_EN ? 8'h06 : 8'h00);
        end
        step();
    endtask

    task automatic test_partial();
        byte_q_t q;
        int miss;
        q = '{8'hAA, 8'hBB};
        pulse_start();
        model_load(q, 1'b1);
        drive_load(q, 1'b1, 1'b0, miss);
        bus.instr_addr_i = 32'd0;
        #1;
        checks++;
        if (miss != 0 || bus.instr_rdata_o !== 32'h0000BBAA || bus.ld_words_o !== 6'd1 ||
            bus.ld_csum_o !== (CSUM_EN ? 8'h65 : 8'h00)) begin
            failures++;
            $display("FAIL partial_word miss=%0d rdata0=%h words=%0d csum=%h required 0000BBAA words=1 csum=%h",
                     miss, bus.instr_rdata_o, bus.ld_words_o, bus.ld_csum_o, CSUM_EN ? 8'h65 : 8'h00);
        end
        bus.instr_addr_i = 32'd1;
        #1;
        checks++;
        if (bus.instr_rdata_o !== 32'h00100093) begin
            failures++;
            $display("FAIL partial_keeps_old rdata1=%h required 00100093", bus.instr_rdata_o);
        end
        step();
    endtask

    task automatic test_random_loads();
        byte_q_t q;
        int miss;
        int n;
        for (int it = 0; it < 8; it++) begin
            q = {};
            n = $urandom_range(1, 48);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            pulse_start();
            checks++;
            if (bus.ld_words_o !== 6'd0 || bus.core_hold_o !== 1'b1) begin
                failures++;
                $display("FAIL rand_start_clear it=%0d words=%0d hold=%b required words=0 hold=1",
                         it, bus.ld_words_o, bus.core_hold_o);
            end
            model_load(q, 1'b1);
            drive_load(q, 1'b1, 1'b1, miss);
            checks++;
            if (miss != 0 || bus.core_hold_o !== 1'b0 || bus.ld_words_o !== 6'(exp_words) ||
                bus.ld_csum_o !== (CSUM_EN ? exp_csum : 8'h00)) begin
                failures++;
                $display("FAIL rand_load_status it=%0d n=%0d miss=%0d hold=%b words=%0d csum=%h required words=%0d csum=%h",
                         it, n, miss, bus.core_hold_o, bus.ld_words_o, bus.ld_csum_o, exp_words,
                         CSUM_EN ? exp_csum : 8'h00);
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (!exp_known[k]) continue;
                bus.instr_addr_i = 32'(k);
                #1;
                checks++;
                if (bus.instr_rdata_o !== exp_mem[k]) begin
                    failures++;
                    $display("FAIL rand_read it=%0d addr=%0d got=%h required=%h",
                             it, k, bus.instr_rdata_o, exp_mem[k]);
                end
            end
            bus.instr_addr_i = 32'($urandom_range(DEPTH, 5000));
            #1;
            checks++;
            if (bus.instr_rdata_o !== 32'h0) begin
                failures++;
                $display("FAIL rand_out_of_range addr=%0d got=%h required=00000000",
                         bus.instr_addr_i, bus.instr_rdata_o);
            end
            step();
        end
    endtask

    task automatic test_full_array();
        byte_q_t q;
        int miss;
        for (int i = 0; i < 4*DEPTH; i++) q.push_back(8'($urandom));
        pulse_start();
        model_load(q, 1'b0);
        drive_load(q, 1'b0, 1'b0, miss);
        checks++;
        if (miss != 0 || bus.ld_words_o !== 6'd32 || bus.core_hold_o !== 1'b0) begin
            failures++;
            $display("FAIL full_status miss=%0d words=%0d hold=%b required words=32 hold=0",
                     miss, bus.ld_words_o, bus.core_hold_o);
        end
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = ~exp_mem[0][7:0];
        #1;
        checks++;
        if (bus.ld_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_ready_low ready=%b required=0", bus.ld_ready_o);
        end
        step();
        bus.ld_valid_i   = 1'b0;
        bus.instr_addr_i = 32'd40;
        #1;
        checks++;
        if (bus.instr_rdata_o !== 32'h0 || bus.ld_words_o !== 6'd32 ||
            bus.ld_csum_o !== (CSUM_EN ? exp_csum : 8'h00)) begin
            failures++;
            $display("FAIL full_after rdata40=%h words=%0d csum=%h required rdata40=0 words=32 csum=%h",
                     bus.instr_rdata_o, bus.ld_words_o, bus.ld_csum_o, CSUM_EN ? exp_csum : 8'h00);
        end
        for (int k = 0; k < DEPTH; k++) begin
            bus.instr_addr_i = 32'(k);
            #1;
            checks++;
            if (bus.instr_rdata_o !== exp_mem[k]) begin
                failures++;
                $display("FAIL full_read addr=%0d got=%h required=%h", k, bus.instr_rdata_o, exp_mem[k]);
            end
        end
        step();
    endtask

    task automatic test_start_collision();
        byte_q_t q;
        byte_q_t pre;
        int miss;
        pre = '{8'($urandom), 8'($urandom)};
        q   = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        pulse_start();
        drive_load(pre, 1'b0, 1'b0, miss);
        bus.ld_start_i = 1'b1;
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = 8'hEE;
        #1;
        checks++;
        if (bus.ld_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL collision_ready ready=%b required=0", bus.ld_ready_o);
        end
        step();
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b0;
        checks++;
        if (bus.ld_words_o !== 6'd0 || bus.ld_csum_o !== 8'h00 || bus.core_hold_o !== 1'b1) begin
            failures++;
            $display("FAIL collision_cleared words=%0d csum=%h hold=%b required words=0 csum=00 hold=1",
                     bus.ld_words_o, bus.ld_csum_o, bus.core_hold_o);
        end
        model_load(q, 1'b1);
        drive_load(q, 1'b1, 1'b0, miss);
        bus.instr_addr_i = 32'd0;
        #1;
        checks++;
        if (miss != 0 || bus.instr_rdata_o !== exp_mem[0] || bus.ld_words_o !== 6'd1 ||
            bus.ld_csum_o !== (CSUM_EN ? exp_csum : 8'h00)) begin
            failures++;
            $display("FAIL collision_word0 miss=%0d rdata0=%h words=%0d csum=%h required %h words=1 csum=%h",
                     miss, bus.instr_rdata_o, bus.ld_words_o, bus.ld_csum_o, exp_mem[0],
                     CSUM_EN ? exp_csum : 8'h00);
        end
        step();
    endtask

    task automatic test_reset_midload();
        byte_q_t q;
        byte_q_t q2;
        int miss;
        for (int i = 0; i < 22; i++) q.push_back(8'($urandom));
        pulse_start();
        model_load(q, 1'b0);
        drive_load(q, 1'b0, 1'b0, miss);
        checks++;
        if (miss != 0 || bus.ld_words_o !== 6'd5) begin
            failures++;
            $display("FAIL midload_progress miss=%0d words=%0d required words=5", miss, bus.ld_words_o);
        end
        bus.ld_valid_i   = 1'b1;
        bus.ld_data_i    = 8'($urandom);
        bus.instr_addr_i = 32'd0;
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (bus.core_hold_o !== 1'b1 || bus.instr_rdata_o !== 32'h0 || bus.ld_words_o !== 6'd0 ||
            bus.ld_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL midload_async hold=%b rdata=%h words=%0d ready=%b required hold=1 rdata=0 words=0 ready=0",
                     bus.core_hold_o, bus.instr_rdata_o, bus.ld_words_o, bus.ld_ready_o);
        end
        bus.ld_valid_i = 1'b0;
        step();
        rst_i = 1'b0;
        step();
        checks++;
        if (bus.core_hold_o !== 1'b1 || bus.ld_ready_o !== 1'b0 || bus.ld_words_o !== 6'd0 ||
            bus.ld_csum_o !== 8'h00) begin
            failures++;
            $display("FAIL midload_idle hold=%b ready=%b words=%0d csum=%h required hold=1 ready=0 words=0 csum=00",
                     bus.core_hold_o, bus.ld_ready_o, bus.ld_words_o, bus.ld_csum_o);
        end
        q2 = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        pulse_start();
        model_load(q2, 1'b1);
        drive_load(q2, 1'b1, 1'b0, miss);
        for (int k = 0; k < 6; k++) begin
            bus.instr_addr_i = 32'(k);
            #1;
            checks++;
            if (bus.instr_rdata_o !== exp_mem[k]) begin
                failures++;
                $display("FAIL midload_reload_read addr=%0d got=%h required=%h", k, bus.instr_rdata_o, exp_mem[k]);
            end
        end
        step();
    endtask

    initial begin
        bus.instr_addr_i = 32'h0;
        bus.ld_start_i   = 1'b0;
        bus.ld_valid_i   = 1'b0;
        bus.ld_data_i    = 8'h00;
        bus.ld_last_i    = 1'b0;
        test_reset();
        test_directed_program();
        test_partial();
        test_random_loads();
        test_full_array();
        test_start_collision();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
